// File: rtl/snespad.sv
// snespad: responder-side model of a SNES controller.
// Takes the console's asynchronous padclk/padlatch strobes, synchronises
// them into the fabric clock domain, and returns the button snapshot on
// paddata one bit per padclk rise (low = pressed).
// Optional feature macro: SNESPAD_TURBO_EN (turbo auto-fire on B and A).
module snespad #(
    parameter int TIMEOUT   = 4096,
    parameter int TURBO_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] buttons,
    input  logic [1:0]  turbo,
    input  logic        padclk,
    input  logic        padlatch,
    output logic        paddata,
    output logic        busy,
    output logic [15:0] reads,
    output logic        timeout
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Synchroniser chains and edge registers for the two pad strobes.
    logic pclk_s1_q, pclk_s2_q, pclk_edge_q;
    logic pclk_s1_d, pclk_s2_d, pclk_edge_d;
    logic plat_s1_q, plat_s2_q, plat_edge_q;
    logic plat_s1_d, plat_s2_d, plat_edge_d;

    // Read datapath.
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   snap_load;
    logic          done_evt_q, done_evt_d;
    logic          to_evt_q, to_evt_d;

    // Registered outputs.
    logic        paddata_q, paddata_d;
    logic        busy_q, busy_d;
    logic [15:0] reads_q, reads_d;
    logic        timeout_q, timeout_d;

    logic clk_rise, lat_rise, lat_fall;

    // Next values of the synchroniser chains: pin -> stage1 -> stage2 -> edge.
    always_comb begin
        pclk_s1_d   = padclk;
        pclk_s2_d   = pclk_s1_q;
        pclk_edge_d = pclk_s2_q;
        plat_s1_d   = padlatch;
        plat_s2_d   = plat_s1_q;
        plat_edge_d = plat_s2_q;
    end

    // Synchroniser registers; clock idles high, latch idles low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pclk_s1_q   <= 1'b1;
            pclk_s2_q   <= 1'b1;
            pclk_edge_q <= 1'b1;
            plat_s1_q   <= 1'b0;
            plat_s2_q   <= 1'b0;
            plat_edge_q <= 1'b0;
        end else begin
            pclk_s1_q   <= pclk_s1_d;
            pclk_s2_q   <= pclk_s2_d;
            pclk_edge_q <= pclk_edge_d;
            plat_s1_q   <= plat_s1_d;
            plat_s2_q   <= plat_s2_d;
            plat_edge_q <= plat_edge_d;
        end
    end

    assign clk_rise = pclk_s2_q & ~pclk_edge_q;
    assign lat_rise = plat_s2_q & ~plat_edge_q;
    assign lat_fall = ~plat_s2_q & plat_edge_q;

`ifdef SNESPAD_TURBO_EN
    localparam int TCW = $clog2(TURBO_DIV + 1);

    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           phase_q, phase_d;

    // Turbo phase: first toggle after TURBO_DIV latch rises, then every
    // TURBO_DIV rises, so the first TURBO_DIV reads see the button released.
    always_comb begin
        tcnt_d  = tcnt_q;
        phase_d = phase_q;
        if (lat_rise) begin
            if (tcnt_q == TCW'(TURBO_DIV)) begin
                tcnt_d  = TCW'(1);
                phase_d = ~phase_q;
            end else begin
                tcnt_d = tcnt_q + TCW'(1);
            end
        end
    end

    // Turbo counter and phase registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            phase_q <= phase_d;
        end
    end

    // Snapshot source with turbo masking on B and A.
    always_comb begin
        snap_load = {4'b0000, buttons};
        if (turbo[0]) snap_load[0] = buttons[0] & phase_q;
        if (turbo[1]) snap_load[8] = buttons[8] & phase_q;
    end
`else
    logic unused_turbo;
    assign unused_turbo = ^turbo;
    assign snap_load    = {4'b0000, buttons};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; a latch rise always wins over a same-cycle clock rise.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (lat_rise) state_d = S_LOAD;
            S_LOAD:  if (lat_fall) state_d = S_SHIFT;
            S_SHIFT: begin
                if (lat_rise)                           state_d = S_LOAD;
                else if (clk_rise && idx_q == 4'd15)    state_d = S_DONE;
                else if (!clk_rise && cnt_q == CNT_MAX) state_d = S_IDLE;
            end
            S_DONE:  if (lat_rise) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: snapshot capture, bit index, inactivity counter.
    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        done_evt_d = 1'b0;
        to_evt_d   = 1'b0;
        case (state_q)
            S_LOAD: begin
                snap_d = snap_load;
                idx_d  = 4'd0;
                cnt_d  = '0;
            end
            S_SHIFT: begin
                if (lat_rise) begin
                    cnt_d = '0;
                end else if (clk_rise) begin
                    idx_d = idx_q + 4'd1;
                    cnt_d = '0;
                    if (idx_q == 4'd15) done_evt_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    to_evt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    // FSM outputs, registered one cycle after the state they reflect.
    always_comb begin
        paddata_d = 1'b1;
        busy_d    = 1'b0;
        case (state_q)
            S_IDLE:  paddata_d = 1'b1;
            S_LOAD:  begin paddata_d = ~snap_q[0];     busy_d = 1'b1; end
            S_SHIFT: begin paddata_d = ~snap_q[idx_q]; busy_d = 1'b1; end
            S_DONE:  paddata_d = 1'b0;
            default: paddata_d = 1'b1;
        endcase
        reads_d   = reads_q + {15'd0, done_evt_q};
        timeout_d = to_evt_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q      <= 4'd0;
            cnt_q      <= '0;
            snap_q     <= 16'd0;
            done_evt_q <= 1'b0;
            to_evt_q   <= 1'b0;
            paddata_q  <= 1'b1;
            busy_q     <= 1'b0;
            reads_q    <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            done_evt_q <= done_evt_d;
            to_evt_q   <= to_evt_d;
            paddata_q  <= paddata_d;
            busy_q     <= busy_d;
            reads_q    <= reads_d;
            timeout_q  <= timeout_d;
        end
    end

    assign paddata = paddata_q;
    assign busy    = busy_q;
    assign reads   = reads_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_snespad.sv
// Testbench for snespad: drives console-side strobes and checks the
// returned serial bits through a queue of expected paddata values.
module tb_snespad;

    localparam int TO = 64;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic [11:0] buttons  = 12'h000;
    logic [1:0]  turbo    = 2'b00;
    logic        padclk   = 1'b1;
    logic        padlatch = 1'b0;
    wire         paddata;
    wire         busy;
    wire  [15:0] reads;
    wire         timeout;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] msnap;

    always #5 clk = ~clk;

    snespad #(.TIMEOUT(TO), .TURBO_DIV(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .buttons  (buttons),
        .turbo    (turbo),
        .padclk   (padclk),
        .padlatch (padlatch),
        .paddata  (paddata),
        .busy     (busy),
        .reads    (reads),
        .timeout  (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic drain_pd();
        @(negedge clk);
        while (exp_q.size() > 0) begin
            string       t;
            logic [15:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, {31'd0, paddata}, {16'd0, e});
        end
    endtask

    task automatic clk_pulse();
        @(negedge clk) padclk = 1'b0;
        cyc(6);
        @(negedge clk) padclk = 1'b1;
        cyc(6);
    endtask

    task automatic latch_pulse(input bit clk_in_load);
        @(negedge clk) padlatch = 1'b1;
        cyc(8);
        if (clk_in_load) clk_pulse();
        @(negedge clk) padlatch = 1'b0;
        cyc(8);
    endtask

    function automatic logic exp_bit(input int k);
        if (k >= 16) return 1'b0;
        return ~msnap[k];
    endfunction

    task automatic read_bits(input int from, input int to, input string tag);
        for (int k = from; k <= to; k++) begin
            clk_pulse();
            push($sformatf("%s_b%0d", tag, k), {15'd0, exp_bit(k)});
            drain_pd();
        end
    endtask

    initial begin
        int  w;
        bit  found;
        logic [3:0] turbo_exp;

        // Reset state
        resetn = 1'b0;
        cyc(3);
        @(negedge clk);
        check("rst_paddata", {31'd0, paddata}, 32'd1);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_reads",   {16'd0, reads},   32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        resetn = 1'b1;
        cyc(4);
        @(negedge clk);
        check("idle_paddata", {31'd0, paddata}, 32'd1);

        // Full read of B and A
        buttons = 12'h101;
        msnap   = {4'h0, 12'h101};
        latch_pulse(1'b0);
        check("full_busy", {31'd0, busy}, 32'd1);
        push("full_b0", {15'd0, exp_bit(0)});
        drain_pd();
        read_bits(1, 16, "full");
        check("full_reads", {16'd0, reads}, 32'd1);
        check("full_busy_done", {31'd0, busy}, 32'd0);

        // Frozen snapshot, with a padclk pulse inside LOAD that must be ignored
        latch_pulse(1'b1);
        buttons = 12'hFFF;
        push("frz_b0", {15'd0, exp_bit(0)});
        drain_pd();
        read_bits(1, 16, "frz");
        check("frz_reads", {16'd0, reads}, 32'd2);

        // Mid-read abort, then the next read restarts at bit 0
        buttons = 12'h101;
        latch_pulse(1'b0);
        push("abt_b0", {15'd0, exp_bit(0)});
        drain_pd();
        read_bits(1, 5, "abt");
        buttons = 12'h002;
        msnap   = {4'h0, 12'h002};
        latch_pulse(1'b0);
        check("abt_reads", {16'd0, reads}, 32'd2);
        push("abt2_b0", {15'd0, exp_bit(0)});
        drain_pd();
        read_bits(1, 16, "abt2");
        check("abt2_reads", {16'd0, reads}, 32'd3);

        // Timeout after 3 bits
        buttons = 12'h101;
        msnap   = {4'h0, 12'h101};
        latch_pulse(1'b0);
        push("to_b0", {15'd0, exp_bit(0)});
        drain_pd();
        read_bits(1, 3, "to");
        w = 0;
        found = 1'b0;
        while (w < 200 && !found) begin
            @(negedge clk);
            w++;
            if (timeout) found = 1'b1;
        end
        check("to_seen", {31'd0, found}, 32'd1);
        check("to_window", {31'd0, (w >= 50 && w <= 70)}, 32'd1);
        @(negedge clk);
        check("to_pulse_width", {31'd0, timeout}, 32'd0);
        check("to_paddata",     {31'd0, paddata}, 32'd1);
        check("to_busy",        {31'd0, busy},    32'd0);
        check("to_reads",       {16'd0, reads},   32'd3);

        // Asynchronous reset in the middle of SHIFT
        latch_pulse(1'b0);
        push("rs_b0", {15'd0, exp_bit(0)});
        drain_pd();
        read_bits(1, 3, "rs");
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("rs_paddata", {31'd0, paddata}, 32'd1);
        check("rs_busy",    {31'd0, busy},    32'd0);
        check("rs_reads",   {16'd0, reads},   32'd0);
        cyc(2);
        @(negedge clk) resetn = 1'b1;
        cyc(4);

`ifdef SNESPAD_TURBO_EN
        // Turbo on B: released, released, pressed, pressed
        buttons   = 12'h001;
        turbo     = 2'b01;
        turbo_exp = 4'b0011;
        for (int r = 0; r < 4; r++) begin
            latch_pulse(1'b0);
            push($sformatf("turbo_r%0d", r), {15'd0, turbo_exp[r]});
            drain_pd();
        end
        turbo = 2'b00;
`else
        turbo_exp = 4'b0000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snespad.md
# snespad

Responder-side model of a SNES controller. It receives the console's serial-clock and latch strobes and returns button states on the serial data line, so the snesctrl reader in the NES top level can be exercised and looped back without a physical pad. The block sits on the fabric clock domain. It synchronises the asynchronous pad strobes and drives paddata from a registered shift state machine.

## Interface

Parameters:
- TIMEOUT, 4096: clk cycles allowed between padclk rising edges in SHIFT before the read is abandoned.
- TURBO_DIV, 4: number of latch pulses per turbo half-period. Used only with SNESPAD_TURBO_EN.

Ports:
- clk  in  1  fabric clock.
- resetn  in  1  asynchronous, active-low reset.
- buttons  in  12  1 = pressed. [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
- turbo  in  2  [0] enables turbo on B, [1] enables turbo on A. Ignored without SNESPAD_TURBO_EN.
- padclk  in  1  console serial clock. Asynchronous to clk. Idles high.
- padlatch  in  1  console latch. Asynchronous to clk. Active high.
- paddata  out  1  wire level; low = pressed.
- busy  out  1  high in LOAD or SHIFT.
- reads  out  16  count of completed 16-bit reads. Wraps 0xFFFF→0.
- timeout  out  1  one-cycle pulse when a read is abandoned.

## Operation

- padclk and padlatch each pass through a 2-flop synchroniser followed by an edge register.
- Rise/fall detection compares synchroniser stage 2 against the edge register.
- Snapshot register snap[15:0]:
  - bits 0..11 hold buttons.
  - bits 12..15 are forced 0 (wire high).
  - The snapshot is loaded every cycle while in LOAD and frozen on leaving LOAD.
- States:
  - IDLE: paddata=1. Latch rise → LOAD.
  - LOAD: paddata=~snap[0]. Latch fall → SHIFT with idx=0. padclk edges in LOAD are ignored.
  - SHIFT: paddata=~snap[idx].
    - On a padclk rise: idx increments and the timeout counter clears.
    - When idx goes from 15 past the end → DONE, and reads increments.
    - When the timeout counter reaches TIMEOUT−1 with no edge → IDLE, and timeout pulses for one cycle.
  - DONE: paddata=0, the genuine-pad trailing level. Latch rise → LOAD. Further padclk edges are ignored.
- A latch rise in SHIFT aborts the current read → LOAD. reads does not increment and no timeout pulse is generated.
- If a latch rise and a padclk rise are detected in the same cycle, the latch wins: the block goes to LOAD and idx is not incremented.
- idx is 4 bits. The timeout counter is wide enough for TIMEOUT−1 and saturates only through the state exit.
- Reset, including reset mid-read, sets:
  - state=IDLE, idx=0, snap=0
  - paddata=1, busy=0, reads=0, timeout=0
  - synchroniser and edge registers to 0 (latch) and 1 (clock).

## Timing

- All outputs are registered.
- A pin transition first sampled at clk edge k is detected at edge k+2. The resulting paddata, busy, reads, or timeout change is visible after edge k+3.
- The snapshot taken is the buttons value present at the last cycle of LOAD, i.e. the cycle in which the latch fall is detected.
- Minimum supported strobe width is 4 clk periods high and 4 low. Narrower pulses may be lost.
- The timeout counter starts at 0 on entry to SHIFT.

## Configuration

- SNESPAD_TURBO_EN defined:
  - An internal latch-rise counter toggles a phase bit every TURBO_DIV latch rises.
  - When turbo[0] is set, snap[0] = buttons[0] & phase. When turbo[1] is set, snap[8] = buttons[8] & phase.
  - The counter and phase reset to 0.
- SNESPAD_TURBO_EN undefined: the turbo port is unused, snap follows buttons directly, and no phase logic is synthesised.

## Test plan

- **Full read:** buttons=12'h101 (B, A); latch pulse, then 16 clock pulses → paddata sequence 0,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1, then 0 in DONE; reads=1.
- **Frozen snapshot:** change buttons to 12'hFFF after the latch fall → shifted bits still reflect 12'h101.
- **Mid-read abort:** latch re-asserted after 5 clocks → no reads increment; the next read starts at bit 0 (B).
- **Timeout:** stop padclk after 3 bits with TIMEOUT=64 → timeout pulses once 64 cycles after the last edge, paddata=1, state IDLE, reads unchanged.
- **Reset mid-SHIFT:** resetn low → paddata=1, busy=0, and reads=0 immediately (asynchronously).
- **Turbo (macro on, TURBO_DIV=2):** B held, turbo=2'b01 → bit 0 reads released, released, pressed, pressed across successive latches.
